snn_sdp_ram: RTL and testbench

Parametrised simple-dual-port RAM for the SNN datapath, used for neuron-state and weight storage. One write port and one read port operate in the same cycle. The block adds a self-clearing sweep after reset or on request, write-first forwarding when a read and a write hit the same address, and an optional output register stage. Read data is qualified by a valid strobe.

---
 rtl/snn_sdp_ram.sv | 76 +++++++
 tb/tb_snn_sdp_ram.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/snn_sdp_ram.sv
// snn_sdp_ram: simple-dual-port RAM with zero sweep, write-first forwarding and optional output stage
module snn_sdp_ram #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 10,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  clear,
   output logic                  busy
);
   typedef enum logic {CLEAR, READY} state_t;
   state_t                state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic                  mem_we, rd_acc, v1;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata, d1;
   assign busy = state == CLEAR;
   always_comb begin
      mem_we    = !rst && (busy || (wr_en && !clear));
      mem_addr  = busy ? ptr : wr_addr;
      mem_wdata = busy ? '0 : wr_data;
      rd_acc    = !rst && !busy && !clear && rd_en;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
         ptr   <= '0;
      end else if (busy) begin
         ptr <= ptr + 1'b1;
         if (&ptr) state <= READY;
      end else if (clear) begin
         state <= CLEAR;
         ptr   <= '0;
      end
   end
   always_ff @(posedge clk)
      if (mem_we) mem[mem_addr] <= mem_wdata;
   // a read hitting the address written this same edge returns the new word
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         d1 <= '0;
      end else begin
         v1 <= rd_acc;
         if (rd_acc) d1 <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
      end
   end
   if (OUT_REG != 0) begin : g_out
      logic                  v2;
      logic [DATA_WIDTH-1:0] d2;
      always_ff @(posedge clk) begin
         if (rst) begin
            v2 <= 1'b0;
            d2 <= '0;
         end else begin
            v2 <= v1;
            if (v1) d2 <= d1;
         end
      end
      assign rd_valid = v2;
      assign rd_data  = d2;
   end else begin : g_noout
      assign rd_valid = v1;
      assign rd_data  = d1;
   end
endmodule

// File: tb/tb_snn_sdp_ram.sv
// tb_snn_sdp_ram: directed checks of three configurations sharing one stimulus stream
module tb_snn_sdp_ram;
   logic       clk, rst, wr_en, rd_en, clear;
   logic [3:0] wr_addr, rd_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_data0, rd_data1, rd_data2;
   logic       rd_valid0, rd_valid1, rd_valid2, busy0, busy1, busy2;
   int         checks = 0, errors = 0;
   typedef struct {
      logic       we;
      logic [3:0] wa;
      logic [7:0] wd;
      logic       re;
      logic [3:0] ra;
      logic       ev;
      logic [7:0] ed;
   } vec_t;
   vec_t tbl[8];
   snn_sdp_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0), .clear(clear), .busy(busy0));
   snn_sdp_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .clear(clear), .busy(busy1));
   snn_sdp_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUT_REG(0), .CLEAR_ON_RESET(0)) u2 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2), .clear(clear), .busy(busy2));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // counts edges until busy drops; optionally pulses clear and requests reads meanwhile
   task automatic sweep_len(input logic pc, input logic rd, output int n, output logic seen);
      n = 0;
      seen = 1'b0;
      while (busy0 && n < 100) begin
         clear = pc && (n == 3 || n == 9);
         rd_en = rd;
         tick;
         n++;
         if (rd_valid0 || rd_valid1) seen = 1'b1;
      end
      clear = 1'b0;
      rd_en = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int   n;
      logic seen, pev;
      logic [7:0] ped;
      tbl[0] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd0,  1'b1, 8'h00};
      tbl[1] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 1'b1, 8'h00};
      tbl[2] = '{1'b1, 4'd5, 8'h3C, 1'b0, 4'd0,  1'b0, 8'h00};
      tbl[3] = '{1'b1, 4'd6, 8'h66, 1'b0, 4'd0,  1'b0, 8'h00};
      tbl[4] = '{1'b1, 4'd5, 8'hA5, 1'b1, 4'd5,  1'b1, 8'hA5};
      tbl[5] = '{1'b1, 4'd5, 8'h11, 1'b1, 4'd6,  1'b1, 8'h66};
      tbl[6] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd5,  1'b1, 8'h11};
      tbl[7] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0,  1'b0, 8'h11};
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0;
      tick;
      rst = 1'b0;
      chk("rst_busy0", busy0, 1);
      chk("rst_busy1", busy1, 1);
      chk("rst_busy2", busy2, 0);
      chk("rst_valid0", rd_valid0, 0);
      chk("rst_data0", rd_data0, 0);
      chk("rst_valid1", rd_valid1, 0);
      sweep_len(1'b0, 1'b0, n, seen);
      chk("init_sweep_len", n, 16);
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_addr = i[3:0]; wr_data = 8'hFF;
         tick;
      end
      wr_en = 1'b0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("rst2_busy0", busy0, 1);
      sweep_len(1'b0, 1'b1, n, seen);
      chk("rst_sweep_len", n, 16);
      chk("rst_sweep_no_valid", seen, 0);
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1; rd_addr = i[3:0];
         tick;
         chk("zero_valid", rd_valid0, 1);
         chk("zero_data", rd_data0, 0);
      end
      rd_en = 1'b0;
      tick;
      pev = 1'b0; ped = 8'h00;
      for (int r = 0; r < 8; r++) begin
         wr_en = tbl[r].we; wr_addr = tbl[r].wa; wr_data = tbl[r].wd;
         rd_en = tbl[r].re; rd_addr = tbl[r].ra;
         tick;
         chk($sformatf("tbl%0d_valid0", r), rd_valid0, tbl[r].ev);
         chk($sformatf("tbl%0d_data0", r), rd_data0, tbl[r].ed);
         chk($sformatf("tbl%0d_valid1", r), rd_valid1, pev);
         chk($sformatf("tbl%0d_data1", r), rd_data1, ped);
         pev = tbl[r].ev; ped = tbl[r].ed;
      end
      tick;
      chk("tbl_tail_valid1", rd_valid1, pev);
      chk("tbl_tail_data1", rd_data1, ped);
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_addr = i[3:0]; wr_data = 8'h10 + i[7:0];
         tick;
      end
      wr_en = 1'b0;
      for (int i = 0; i < 18; i++) begin
         rd_en = i < 16; rd_addr = i[3:0];
         tick;
         chk($sformatf("strm%0d_valid1", i), rd_valid1, i >= 1 && i <= 16);
         if (i >= 1 && i <= 16) chk($sformatf("strm%0d_data1", i), rd_data1, 8'h10 + i - 1);
         if (i < 16) chk($sformatf("strm%0d_data0", i), rd_data0, 8'h10 + i);
      end
      rd_en = 1'b1; rd_addr = 4'd3;
      tick;
      chk("pre_clr_valid0", rd_valid0, 1);
      chk("pre_clr_data0", rd_data0, 8'h13);
      clear = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h77; rd_addr = 4'd2;
      tick;
      clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      chk("clr_drop_valid0", rd_valid0, 0);
      chk("clr_inflight_valid1", rd_valid1, 1);
      chk("clr_inflight_data1", rd_data1, 8'h13);
      chk("clr_busy0", busy0, 1);
      sweep_len(1'b0, 1'b0, n, seen);
      chk("clr_sweep_len", n, 16);
      chk("clr_no_valid", seen, 0);
      rd_en = 1'b1; rd_addr = 4'd2;
      tick;
      rd_en = 1'b0;
      chk("clr_a2_valid0", rd_valid0, 1);
      chk("clr_a2_data0", rd_data0, 0);
      tick;
      chk("clr_a2_valid1", rd_valid1, 1);
      chk("clr_a2_data1", rd_data1, 0);
      clear = 1'b1;
      tick;
      clear = 1'b0;
      repeat (7) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("mid_rst_busy0", busy0, 1);
      sweep_len(1'b1, 1'b1, n, seen);
      chk("mid_rst_sweep_len", n, 16);
      chk("mid_rst_no_valid", seen, 0);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("cor0_busy2", busy2, 0);
      chk("cor0_valid2", rd_valid2, 0);
      chk("cor0_data2", rd_data2, 0);
      wr_en = 1'b1; wr_addr = 4'd15; wr_data = 8'h42;
      tick;
      wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd15;
      tick;
      rd_en = 1'b0;
      chk("cor0_rd_valid2", rd_valid2, 1);
      chk("cor0_rd_data2", rd_data2, 8'h42);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
